counter_mode_scheduler: RTL and testbench

//   Sequences the four lab down-counters (ripple, synchronous, Johnson, schematic) in the
//   Lab 1 top level. Only one counter runs at a time. The block clears the counter it is

---
 rtl/counter_mode_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_counter_mode_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mode_scheduler.sv
// counter_mode_scheduler: runs one of four lab down-counters at a time,
// clears the counter being switched to, gates it with the divider tick
// and registers its value for the LEDs. Switching happens on request or
// by auto-rotation after DWELL_TICKS ticks.
// Ports: clk, rst (sync, active-low), tick, start, mode_req, mode_sel,
//   auto_en, cnt_bus (4 x DW) in; cnt_en, cnt_clr (one-hot), count_out,
//   active_mode, busy out.
// Optional: define UNDERFLOW_COUNT_EN to add wrap_cnt[7:0], a saturating
//   count of 0 -> all-ones transitions of count_out while running.
module counter_mode_scheduler #(
  parameter int DW          = 4,
  parameter int DWELL_TICKS = 16,
  parameter int CLR_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            start,
  input  logic            mode_req,
  input  logic [1:0]      mode_sel,
  input  logic            auto_en,
  input  logic [4*DW-1:0] cnt_bus,
  output logic [3:0]      cnt_en,
  output logic [3:0]      cnt_clr,
  output logic [DW-1:0]   count_out,
  output logic [1:0]      active_mode,
`ifdef UNDERFLOW_COUNT_EN
  output logic [7:0]      wrap_cnt,
`endif
  output logic            busy
);

  localparam int DWW = $clog2(DWELL_TICKS + 1);
  localparam int CW  = $clog2(CLR_CYCLES + 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_TICKS - 1);
  localparam logic [CW-1:0]  CLR_LAST   = CW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    RUN     = 2'd2,
    HANDOFF = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [CW-1:0]   clr_q, clr_d;
  logic [DWW-1:0]  dwell_q, dwell_d;
  logic            pend_q, pend_d;
  logic [1:0]      psel_q, psel_d;
  logic [DW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            req_v;
  logic [1:0]      req_m;
  logic            enter_clr;
  logic [3:0]      mode_oh;

  assign mode_oh = 4'b0001 << mode_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tgt_d     = tgt_q;
    clr_d     = clr_q;
    dwell_d   = dwell_q;
    pend_d    = pend_q;
    psel_d    = psel_q;
    count_d   = count_q;
    req_v     = 1'b0;
    req_m     = mode_q;
    enter_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          state_d = CLEAR;
          tgt_d   = mode_q;
        end
      end
      CLEAR: begin
        if (mode_req) begin
          pend_d = 1'b1;
          psel_d = mode_sel;
        end
        if (clr_q == CLR_LAST) begin
          state_d = RUN;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      RUN: begin
        count_d = cnt_bus[DW*int'(mode_q) +: DW];
        // a fresh request overrides one held over from the switch
        pend_d  = 1'b0;
        req_v   = mode_req | pend_q;
        req_m   = mode_req ? mode_sel : psel_q;
        if (!start) begin
          state_d = IDLE;
        end else if (req_v && (req_m != mode_q)) begin
          state_d = HANDOFF;
          tgt_d   = req_m;
        end else if (auto_en && tick) begin
          if (dwell_q == DWELL_LAST) begin
            state_d = HANDOFF;
            tgt_d   = mode_q + 2'd1;
          end else begin
            dwell_d = dwell_q + DWW'(1);
          end
        end
      end
      HANDOFF: begin
        if (mode_req) begin
          pend_d = 1'b1;
          psel_d = mode_sel;
        end
        state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == CLEAR) && (state_q != CLEAR)) begin
      enter_clr = 1'b1;
      mode_d    = tgt_d;
      clr_d     = '0;
      dwell_d   = '0;
    end
    busy_d = (state_d == HANDOFF) || (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      tgt_q   <= '0;
      clr_q   <= '0;
      dwell_q <= '0;
      pend_q  <= 1'b0;
      psel_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      clr_q   <= clr_d;
      dwell_q <= dwell_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_en      = ((state_q == RUN) && tick) ? mode_oh : 4'b0000;
  assign cnt_clr     = (state_q == CLEAR) ? mode_oh : 4'b0000;
  assign count_out   = count_q;
  assign active_mode = mode_q;
  assign busy        = busy_q;

`ifdef UNDERFLOW_COUNT_EN
  logic [7:0] wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (enter_clr) begin
      wrap_d = '0;
    end else if ((state_q == RUN) && (count_q == '0) &&
                 (count_d == '1) && (wrap_q != 8'hFF)) begin
      wrap_d = wrap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_counter_mode_scheduler.sv
// Bench for counter_mode_scheduler: directed scenarios plus random traffic
// scored against a phase/countdown reference model via an expectation queue.
module tb_counter_mode_scheduler;

  localparam int DW    = 4;
  localparam int DWELL = 4;
  localparam int CLRC  = 2;
  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_HO   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        start;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        auto_en;
  logic [15:0] cnt_bus;
  logic [3:0]  cnt_en;
  logic [3:0]  cnt_clr;
  logic [3:0]  count_out;
  logic [1:0]  active_mode;
  logic        busy;
  logic [7:0]  wrap_cnt;

  always #5 clk = ~clk;

  counter_mode_scheduler #(
    .DW(DW),
    .DWELL_TICKS(DWELL),
    .CLR_CYCLES(CLRC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .mode_req(mode_req),
    .mode_sel(mode_sel),
    .auto_en(auto_en),
    .cnt_bus(cnt_bus),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .count_out(count_out),
    .active_mode(active_mode),
`ifdef UNDERFLOW_COUNT_EN
    .wrap_cnt(wrap_cnt),
`endif
    .busy(busy)
  );

`ifndef UNDERFLOW_COUNT_EN
  assign wrap_cnt = 8'd0;
`endif

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] clr;
    logic [3:0] cnt;
    logic [1:0] mode;
    logic       busy;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: spec-level phase, countdowns and a pending list
  int   m_ph;
  int   m_mode;
  int   m_tgt;
  int   m_clr_left;
  int   m_dwell;
  int   m_count;
  int   m_wrap;
  int   m_pend[$];
  bit   m_known = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      bit ok;
      mon_e = sb.pop_front();
      ok = (cnt_en === mon_e.en) && (cnt_clr === mon_e.clr) &&
           (count_out === mon_e.cnt) &&
           (active_mode === mon_e.mode) && (busy === mon_e.busy);
`ifdef UNDERFLOW_COUNT_EN
      ok = ok && (wrap_cnt === mon_e.wrap);
`endif
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL outputs t=%0t got en=%b clr=%b cnt=%h mode=%0d busy=%b wrap=%0d want en=%b clr=%b cnt=%h mode=%0d busy=%b wrap=%0d",
                 $time, cnt_en, cnt_clr, count_out, active_mode, busy,
                 wrap_cnt, mon_e.en, mon_e.clr, mon_e.cnt, mon_e.mode,
                 mon_e.busy, mon_e.wrap);
      end
    end
  end

  task automatic go_clear(input int t);
    m_ph       = P_CLR;
    m_mode     = t;
    m_clr_left = CLRC;
    m_dwell    = 0;
    m_wrap     = 0;
  endtask

  task automatic hold_req(input bit q, input int sel);
    if (q) begin
      m_pend.delete();
      m_pend.push_back(sel);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit t,
                            input bit q, input int sel, input bit a,
                            input logic [15:0] bus);
    int nv;
    int want;
    if (!r) begin
      m_ph    = P_IDLE;
      m_mode  = 0;
      m_count = 0;
      m_dwell = 0;
      m_wrap  = 0;
      m_pend.delete();
      m_known = 1;
    end else if (m_known) begin
      case (m_ph)
        P_IDLE: begin
          m_pend.delete();
          if (s) go_clear(m_mode);
        end
        P_CLR: begin
          hold_req(q, sel);
          m_clr_left--;
          if (m_clr_left == 0) m_ph = P_RUN;
        end
        P_RUN: begin
          nv = int'((bus >> (4 * m_mode)) & 16'hF);
          if (m_count == 0 && nv == 15 && m_wrap < 255) m_wrap++;
          m_count = nv;
          want = q ? sel : (m_pend.size() > 0 ? m_pend[0] : -1);
          m_pend.delete();
          if (!s) begin
            m_ph = P_IDLE;
          end else if (want >= 0 && want != m_mode) begin
            m_ph  = P_HO;
            m_tgt = want;
          end else if (a && t) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
              m_ph  = P_HO;
              m_tgt = (m_mode + 1) % 4;
            end
          end
        end
        default: begin
          hold_req(q, sel);
          go_clear(m_tgt);
        end
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit t, input bit q,
                     input logic [1:0] sel, input bit a,
                     input logic [15:0] bus);
    exp_t e;
    rst      = r;
    start    = s;
    tick     = t;
    mode_req = q;
    mode_sel = sel;
    auto_en  = a;
    cnt_bus  = bus;
    if (m_known) begin
      e.en   = (m_ph == P_RUN && t) ? 4'(1 << m_mode) : 4'd0;
      e.clr  = (m_ph == P_CLR) ? 4'(1 << m_mode) : 4'd0;
      e.cnt  = 4'(m_count);
      e.mode = 2'(m_mode);
      e.busy = (m_ph == P_CLR) || (m_ph == P_HO);
      e.wrap = 8'(m_wrap);
      sb.push_back(e);
    end
    model_step(r, s, t, q, int'(sel), a, bus);
    @(posedge clk);
    #1;
  endtask

  task automatic until_run(input bit a, input logic [15:0] bus);
    int n;
    n = 0;
    while (m_ph != P_RUN && n < 20) begin
      cyc(1, 1, 0, 0, 2'd0, a, bus);
      n++;
    end
  endtask

  function automatic logic [15:0] rnd_bus();
    logic [15:0] b;
    b = 16'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      for (int k = 0; k < 4; k++) begin
        b[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
      end
    end
    return b;
  endfunction

  initial begin
    logic [15:0] bus;
    rst = 1'b0; start = 1'b0; tick = 1'b0; mode_req = 1'b0;
    mode_sel = 2'd0; auto_en = 1'b0; cnt_bus = 16'd0;
    #1;
    repeat (2) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom),
                   2'($urandom), 1'($urandom), 16'($urandom));

    bus = 16'h5A39;
    cyc(1, 1, 0, 0, 2'd0, 0, bus);
    until_run(0, bus);
    for (int i = 0; i < 6; i++) cyc(1, 1, (i % 2 == 0), 0, 2'd0, 0, bus);

    cyc(1, 1, 1, 1, 2'd2, 0, bus);
    until_run(0, bus);
    cyc(1, 1, 1, 1, 2'd2, 0, bus);
    repeat (3) cyc(1, 1, 1, 0, 2'd0, 0, bus);

    cyc(1, 1, 0, 1, 2'd3, 0, bus);
    until_run(0, bus);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 1, 0, 2'd0, 1, bus);
      cyc(1, 1, 0, 0, 2'd0, 1, bus);
    end
    until_run(1, bus);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 0, 2'd0, 1, bus);
      cyc(1, 1, 0, 0, 2'd0, 1, bus);
    end
    cyc(1, 1, 1, 1, 2'd1, 1, bus);
    until_run(0, bus);

    cyc(1, 1, 0, 1, 2'd2, 0, bus);
    cyc(1, 1, 0, 0, 2'd0, 0, bus);
    cyc(1, 1, 1, 1, 2'd3, 0, bus);
    cyc(1, 1, 1, 1, 2'd1, 0, bus);
    repeat (8) cyc(1, 1, 1, 0, 2'd0, 0, bus);

    cyc(1, 1, 0, 1, 2'd0, 0, bus);
    cyc(1, 1, 0, 0, 2'd0, 0, bus);
    cyc(0, 1, 1, 1, 2'd2, 1, bus);
    repeat (2) cyc(1, 0, 0, 0, 2'd0, 0, bus);

    cyc(1, 1, 0, 0, 2'd0, 0, 16'h0000);
    until_run(0, 16'h0000);
    cyc(1, 1, 0, 0, 2'd0, 0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 1, 0, 2'd0, 0, 16'h000F);
      cyc(1, 1, 1, 0, 2'd0, 0, 16'h0000);
    end
    repeat (2) cyc(1, 1, 0, 0, 2'd0, 0, 16'h0000);
    cyc(1, 0, 0, 0, 2'd0, 0, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 15) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
          2'($urandom), $urandom_range(0, 3) != 0, rnd_bus());
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
